// File: rtl/global_typs_pkg.sv
// global_typs_pkg
//   Shared types and constants for the IPv4 transmit framer.
//   - ipv4_tx_type: upstream request header plus payload byte stream.
//   - IPTX_* result codes reported back to the upstream UDP block.
//   - Ethernet / IPv4 framing constants and the framer FSM state type.
package global_typs_pkg;

  typedef struct packed {
    logic [7:0]  protocol;
    logic [15:0] data_length;
    logic [31:0] dst_ip_addr;
  } ipv4_tx_hdr_type;

  typedef struct packed {
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_last;
  } ipv4_tx_data_type;

  typedef struct packed {
    ipv4_tx_hdr_type  hdr;
    ipv4_tx_data_type data;
  } ipv4_tx_type;

  localparam logic [1:0] IPTX_NORMAL  = 2'b00;
  localparam logic [1:0] IPTX_SENDING = 2'b01;
  localparam logic [1:0] IPTX_ERR     = 2'b10;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam int          IPV4_HDR_LEN   = 20;
  localparam int          ETH_HDR_LEN    = 14;

  // Last header byte index (Ethernet + IPv4 header, zero based).
  localparam logic [5:0]  HDR_LAST_IDX   = 6'(ETH_HDR_LEN + IPV4_HDR_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_GRANT,
    ST_SEND_HDR,
    ST_SEND_DATA
  } tx_state_e;

endpackage

// File: rtl/ipv4_tx_framer_if.sv
// ipv4_tx_framer_if
//   Bundles the framer's upstream request/payload side and its MAC transmit
//   side.
//   - slave : view used by ipv4_tx_framer (consumes requests, drives the MAC
//             stream and the request line).
//   - master: view used by the environment (UDP block + MAC arbiter/sink).
//   Signals:
//     ip_tx_start, ip_tx, dst_mac           request + payload from upstream
//     ip_tx_result, ip_tx_data_out_ready    status/backpressure to upstream
//     mac_tx_req, mac_tx_granted            MAC path arbitration
//     mac_tx_tvalid/tready/tlast/tdata      byte stream toward the MAC
interface ipv4_tx_framer_if;
  import global_typs_pkg::*;

  logic        ip_tx_start;
  ipv4_tx_type ip_tx;
  logic [1:0]  ip_tx_result;
  logic        ip_tx_data_out_ready;
  logic [47:0] dst_mac;
  logic        mac_tx_req;
  logic        mac_tx_granted;
  logic        mac_tx_tready;
  logic        mac_tx_tvalid;
  logic        mac_tx_tlast;
  logic [7:0]  mac_tx_tdata;

  modport slave (
    input  ip_tx_start, ip_tx, dst_mac, mac_tx_granted, mac_tx_tready,
    output ip_tx_result, ip_tx_data_out_ready, mac_tx_req,
           mac_tx_tvalid, mac_tx_tlast, mac_tx_tdata
  );

  modport master (
    output ip_tx_start, ip_tx, dst_mac, mac_tx_granted, mac_tx_tready,
    input  ip_tx_result, ip_tx_data_out_ready, mac_tx_req,
           mac_tx_tvalid, mac_tx_tlast, mac_tx_tdata
  );

endinterface

// File: rtl/ipv4_hdr_checksum.sv
// ipv4_hdr_checksum
//   Combinational IPv4 header checksum over the ten header words with the
//   checksum word taken as zero. The parent registers the result.
//   Fixed words: 0x4500 (ver/IHL/TOS), 0x4000 (flags DF, frag offset 0).
//   Ports:
//     total_length, identification  variable 16-bit header words
//     ttl, protocol                 packed into one header word
//     src_ip, dst_ip                addresses, two words each
//     checksum                      inverted folded one's-complement sum
module ipv4_hdr_checksum (
  input  logic [15:0] total_length,
  input  logic [15:0] identification,
  input  logic [7:0]  ttl,
  input  logic [7:0]  protocol,
  input  logic [31:0] src_ip,
  input  logic [31:0] dst_ip,
  output logic [15:0] checksum
);

  logic [19:0] sum;
  logic [16:0] fold1;
  logic [15:0] fold2;

  // Ten 16-bit words fit in 20 bits; two folds absorb every carry.
  always_comb begin
    sum   = 20'h0_4500 + 20'(total_length) + 20'(identification) + 20'h0_4000
          + 20'({ttl, protocol})
          + 20'(src_ip[31:16]) + 20'(src_ip[15:0])
          + 20'(dst_ip[31:16]) + 20'(dst_ip[15:0]);
    fold1 = 17'(sum[15:0]) + 17'(sum[19:16]);
    fold2 = fold1[15:0] + 16'(fold1[16]);
    checksum = ~fold2;
  end

endmodule

// File: rtl/ipv4_tx_framer.sv
// ipv4_tx_framer
//   Transmit IPv4 framing stage. Accepts a request on the bus, arbitrates for
//   the MAC path, emits a 14-byte Ethernet header and a 20-byte IPv4 header
//   (with checksum), then passes the upstream payload straight through.
//   Ports:
//     clk    system clock
//     reset  synchronous active-high reset
//     bus    ipv4_tx_framer_if.slave (request, payload, MAC stream)
//   Parameters: OUR_IP, OUR_MAC, TTL, MAX_DATA_LEN.
//   Build option: define IPV4_TX_LEN_CHECK_EN to count accepted payload bytes
//   and report IPTX_ERR at frame end if the count differs from data_length.
module ipv4_tx_framer
  import global_typs_pkg::*;
#(
  parameter logic [31:0] OUR_IP       = 32'hC0A8_0001,
  parameter logic [47:0] OUR_MAC      = 48'h0023_2045_0001,
  parameter logic [7:0]  TTL          = 8'd128,
  parameter logic [15:0] MAX_DATA_LEN = 16'd1480
) (
  input logic             clk,
  input logic             reset,
  ipv4_tx_framer_if.slave bus
);

  tx_state_e       state_q, state_d;
  logic [5:0]      byte_cnt_q, byte_cnt_d;
  logic [15:0]     id_q, id_d;
  logic [1:0]      result_q, result_d;
  logic [47:0]     dst_mac_q, dst_mac_d;
  ipv4_tx_hdr_type hdr_q, hdr_d;
  logic [15:0]     cksum_q, cksum_d;

  logic [15:0]     cksum_w;
  logic [15:0]     total_len;
  logic [271:0]    hdr_vec;
  logic [8:0]      bsel;
  logic            hdr_acc, hdr_last, pay_acc, pay_done, frame_err;

`ifdef IPV4_TX_LEN_CHECK_EN
  logic [15:0]     pay_cnt_q, pay_cnt_d;
`endif

  assign total_len = hdr_q.data_length + 16'(IPV4_HDR_LEN);

  ipv4_hdr_checksum u_cksum (
    .total_length   (total_len),
    .identification (id_q),
    .ttl            (TTL),
    .protocol       (hdr_q.protocol),
    .src_ip         (OUR_IP),
    .dst_ip         (hdr_q.dst_ip_addr),
    .checksum       (cksum_w)
  );

  // Whole 34-byte header laid out MSB first; byte n sits at bits
  // [(33-n)*8 +: 8], so the counter selects without a wide case.
  assign hdr_vec = {dst_mac_q, OUR_MAC, ETHERTYPE_IPV4,
                    8'h45, 8'h00, total_len, id_q, 8'h40, 8'h00,
                    TTL, hdr_q.protocol, cksum_q, OUR_IP, hdr_q.dst_ip_addr};
  assign bsel    = {HDR_LAST_IDX - byte_cnt_q, 3'b000};

  // Header bytes are always valid in SEND_HDR, so tready alone accepts.
  assign hdr_acc  = (state_q == ST_SEND_HDR) && bus.mac_tx_tready;
  assign hdr_last = (byte_cnt_q == HDR_LAST_IDX);
  assign pay_acc  = (state_q == ST_SEND_DATA) && bus.ip_tx.data.data_out_valid
                    && bus.mac_tx_tready;
  assign pay_done = pay_acc && bus.ip_tx.data.data_out_last;

`ifdef IPV4_TX_LEN_CHECK_EN
  // pay_cnt_q excludes the last byte being accepted now.
  assign frame_err = (pay_cnt_q + 16'd1) != hdr_q.data_length;
`else
  assign frame_err = 1'b0;
`endif

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt_q <= '0;
      id_q       <= '0;
      result_q   <= IPTX_NORMAL;
      dst_mac_q  <= '0;
      hdr_q      <= '0;
      cksum_q    <= '0;
`ifdef IPV4_TX_LEN_CHECK_EN
      pay_cnt_q  <= '0;
`endif
    end else begin
      byte_cnt_q <= byte_cnt_d;
      id_q       <= id_d;
      result_q   <= result_d;
      dst_mac_q  <= dst_mac_d;
      hdr_q      <= hdr_d;
      cksum_q    <= cksum_d;
`ifdef IPV4_TX_LEN_CHECK_EN
      pay_cnt_q  <= pay_cnt_d;
`endif
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    id_d       = id_q;
    result_d   = result_q;
    dst_mac_d  = dst_mac_q;
    hdr_d      = hdr_q;
    cksum_d    = cksum_q;
`ifdef IPV4_TX_LEN_CHECK_EN
    pay_cnt_d  = pay_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.ip_tx_start) begin
          if (bus.ip_tx.hdr.data_length > MAX_DATA_LEN) begin
            result_d = IPTX_ERR;
          end else begin
            hdr_d     = bus.ip_tx.hdr;
            dst_mac_d = bus.dst_mac;
            result_d  = IPTX_SENDING;
            state_d   = ST_WAIT_GRANT;
`ifdef IPV4_TX_LEN_CHECK_EN
            pay_cnt_d = '0;
`endif
          end
        end
      end
      ST_WAIT_GRANT: begin
        // Latched fields are stable here, so the first WAIT_GRANT cycle
        // already registers the final checksum.
        cksum_d = cksum_w;
        if (bus.mac_tx_granted) begin
          state_d    = ST_SEND_HDR;
          byte_cnt_d = '0;
        end
      end
      ST_SEND_HDR: begin
        if (hdr_acc) begin
          if (hdr_last) begin
            byte_cnt_d = '0;
            // Zero-length payload: the frame ends on the last header byte.
            if (hdr_q.data_length == '0) begin
              state_d  = ST_IDLE;
              id_d     = id_q + 16'd1;
              result_d = IPTX_NORMAL;
            end else begin
              state_d  = ST_SEND_DATA;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 6'd1;
          end
        end
      end
      ST_SEND_DATA: begin
`ifdef IPV4_TX_LEN_CHECK_EN
        if (pay_acc) pay_cnt_d = pay_cnt_q + 16'd1;
`endif
        if (pay_done) begin
          state_d  = ST_IDLE;
          id_d     = id_q + 16'd1;
          result_d = frame_err ? IPTX_ERR : IPTX_NORMAL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    bus.mac_tx_req           = 1'b0;
    bus.mac_tx_tvalid        = 1'b0;
    bus.mac_tx_tlast         = 1'b0;
    bus.mac_tx_tdata         = 8'h00;
    bus.ip_tx_data_out_ready = 1'b0;
    case (state_q)
      ST_WAIT_GRANT: begin
        bus.mac_tx_req = 1'b1;
      end
      ST_SEND_HDR: begin
        bus.mac_tx_req    = 1'b1;
        bus.mac_tx_tvalid = 1'b1;
        bus.mac_tx_tdata  = hdr_vec[bsel +: 8];
        bus.mac_tx_tlast  = hdr_last && (hdr_q.data_length == '0);
      end
      ST_SEND_DATA: begin
        // Zero-latency pass-through of the upstream stream.
        bus.mac_tx_req           = 1'b1;
        bus.mac_tx_tvalid        = bus.ip_tx.data.data_out_valid;
        bus.mac_tx_tlast         = bus.ip_tx.data.data_out_last;
        bus.mac_tx_tdata         = bus.ip_tx.data.data_out;
        bus.ip_tx_data_out_ready = bus.mac_tx_tready;
      end
      default: ;
    endcase
  end

  assign bus.ip_tx_result = result_q;

endmodule

// File: tb/tb_ipv4_tx_framer.sv
// tb_ipv4_tx_framer
//   Directed sequence with random payloads and random tready/valid stalls,
//   checked against a byte-queue reference frame built from the field rules.
module tb_ipv4_tx_framer;
  import global_typs_pkg::*;

  localparam logic [31:0] P_OUR_IP  = 32'hC0A8_0001;
  localparam logic [47:0] P_OUR_MAC = 48'h0023_2045_0001;
  localparam logic [7:0]  P_TTL     = 8'd128;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ipv4_tx_framer_if bus();

  ipv4_tx_framer #(
    .OUR_IP       (P_OUR_IP),
    .OUR_MAC      (P_OUR_MAC),
    .TTL          (P_TTL),
    .MAX_DATA_LEN (16'd1480)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;
  int exp_id = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic       got_last[$];
  logic [7:0] pay[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_bytes(input logic [47:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(v[i*8 +: 8]);
  endtask

  // Reference frame: fields in wire order, checksum over header words 14..33.
  task automatic build_expected(input logic [15:0] len, input logic [7:0] proto,
                                input logic [31:0] dip, input logic [47:0] dmac,
                                input logic [15:0] id);
    int unsigned s;
    logic [15:0] ck;
    exp_q = {};
    push_bytes(dmac, 6);
    push_bytes(P_OUR_MAC, 6);
    push_bytes(48'h0800, 2);
    push_bytes(48'h4500, 2);
    push_bytes(48'(len + 16'd20), 2);
    push_bytes(48'(id), 2);
    push_bytes(48'h4000, 2);
    push_bytes(48'(P_TTL), 1);
    push_bytes(48'(proto), 1);
    push_bytes(48'h0, 2);
    push_bytes(48'(P_OUR_IP), 4);
    push_bytes(48'(dip), 4);
    s = 0;
    for (int i = 14; i < 34; i += 2) s += {16'h0, exp_q[i], exp_q[i+1]};
    while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
    ck = ~16'(s);
    exp_q[24] = ck[15:8];
    exp_q[25] = ck[7:0];
    foreach (pay[i]) exp_q.push_back(pay[i]);
  endtask

  task automatic idle_inputs();
    bus.ip_tx_start                = 1'b0;
    bus.mac_tx_granted             = 1'b0;
    bus.ip_tx.data.data_out_valid  = 1'b0;
    bus.ip_tx.data.data_out_last   = 1'b0;
    bus.ip_tx.data.data_out        = 8'h00;
  endtask

  task automatic send_frame(input string tag, input logic [15:0] len,
                            input logic [7:0] proto, input logic [31:0] dip,
                            input logic [47:0] dmac, input int n_del,
                            input int gdly, input bit stall, input int abort_at);
    int pidx = 0;
    int cyc = 0;
    bit done = 0;
    bit prev_stall = 0;
    bit up_acc;
    logic [7:0] prev_d = 8'h00;
    logic [1:0] exp_res;

    pay = {};
    for (int i = 0; i < n_del; i++) pay.push_back(8'($urandom));
    got_q = {};
    got_last = {};

    bus.ip_tx_start            = 1'b1;
    bus.ip_tx.hdr.protocol     = proto;
    bus.ip_tx.hdr.data_length  = len;
    bus.ip_tx.hdr.dst_ip_addr  = dip;
    bus.dst_mac                = dmac;
    @(posedge clk); #1;
    // Scramble request fields: the framer must use what it latched.
    bus.ip_tx_start = 1'b0;
    bus.ip_tx.hdr   = ~bus.ip_tx.hdr;
    bus.dst_mac     = ~dmac;

    if (len > 16'd1480) begin
      chk({tag, "_result_err"}, bus.ip_tx_result, IPTX_ERR);
      chk({tag, "_no_req"}, bus.mac_tx_req, 1'b0);
      repeat (3) begin
        @(posedge clk); #1;
        chk({tag, "_no_req_hold"}, bus.mac_tx_req, 1'b0);
        chk({tag, "_err_persist"}, bus.ip_tx_result, IPTX_ERR);
      end
      return;
    end

    chk({tag, "_result_sending"}, bus.ip_tx_result, IPTX_SENDING);
    chk({tag, "_req_up"}, bus.mac_tx_req, 1'b1);
    repeat (gdly) begin
      @(posedge clk); #1;
      chk({tag, "_wait_novalid"}, bus.mac_tx_tvalid, 1'b0);
    end
    bus.mac_tx_granted = 1'b1;
    @(posedge clk); #1;
    bus.mac_tx_granted = 1'b0;
    chk({tag, "_valid_after_grant"}, bus.mac_tx_tvalid, 1'b1);

    build_expected(len, proto, dip, dmac, 16'(exp_id));

    while (!done && cyc < 5000) begin
      bus.mac_tx_tready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.ip_tx.data.data_out_valid = (pidx < n_del) &&
                                      (!stall || prev_stall || $urandom_range(0, 3) != 0);
      bus.ip_tx.data.data_out_last  = (pidx == n_del - 1);
      if (pidx < n_del) bus.ip_tx.data.data_out = pay[pidx];
      else              bus.ip_tx.data.data_out = 8'h00;
      @(negedge clk);
      if (abort_at >= 0 && got_q.size() == abort_at) begin
        chk({tag, "_abort_byte"}, bus.mac_tx_tdata, exp_q[abort_at]);
        reset = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_rst_req"}, bus.mac_tx_req, 1'b0);
        chk({tag, "_rst_tvalid"}, bus.mac_tx_tvalid, 1'b0);
        chk({tag, "_rst_tlast"}, bus.mac_tx_tlast, 1'b0);
        chk({tag, "_rst_tdata"}, bus.mac_tx_tdata, 8'h00);
        chk({tag, "_rst_ready"}, bus.ip_tx_data_out_ready, 1'b0);
        chk({tag, "_rst_result"}, bus.ip_tx_result, IPTX_NORMAL);
        reset = 1'b0;
        exp_id = 0;
        idle_inputs();
        return;
      end
      if (prev_stall) begin
        chk({tag, "_hold_tvalid"}, bus.mac_tx_tvalid, 1'b1);
        chk({tag, "_hold_tdata"}, bus.mac_tx_tdata, prev_d);
      end
      if (bus.mac_tx_tvalid && bus.mac_tx_tready) begin
        got_q.push_back(bus.mac_tx_tdata);
        got_last.push_back(bus.mac_tx_tlast);
        if (bus.mac_tx_tlast) done = 1;
      end
      prev_stall = bus.mac_tx_tvalid && !bus.mac_tx_tready;
      prev_d     = bus.mac_tx_tdata;
      up_acc     = bus.ip_tx_data_out_ready && bus.ip_tx.data.data_out_valid;
      @(posedge clk); #1;
      cyc++;
      if (up_acc) pidx++;
    end
    idle_inputs();
    if (!done) chk({tag, "_frame_timeout"}, 1'b0, 1'b1);

`ifdef IPV4_TX_LEN_CHECK_EN
    exp_res = (n_del != int'(len)) ? IPTX_ERR : IPTX_NORMAL;
`else
    exp_res = IPTX_NORMAL;
`endif
    chk({tag, "_req_drop"}, bus.mac_tx_req, 1'b0);
    chk({tag, "_result_end"}, bus.ip_tx_result, exp_res);
    chk({tag, "_ready_idle"}, bus.ip_tx_data_out_ready, 1'b0);
    chk({tag, "_payload_consumed"}, pidx, n_del);
    chk({tag, "_frame_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
      chk($sformatf("%s_tlast%0d", tag, i), got_last[i], i == exp_q.size() - 1);
    end
    exp_id = (exp_id + 1) & 16'hFFFF;
  endtask

  initial begin
    reset = 1'b1;
    bus.mac_tx_tready = 1'b0;
    bus.ip_tx.hdr = '0;
    bus.dst_mac = '0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_result", bus.ip_tx_result, IPTX_NORMAL);
    chk("rst_ready", bus.ip_tx_data_out_ready, 1'b0);
    chk("rst_req", bus.mac_tx_req, 1'b0);
    chk("rst_tvalid", bus.mac_tx_tvalid, 1'b0);
    chk("rst_tlast", bus.mac_tx_tlast, 1'b0);
    chk("rst_tdata", bus.mac_tx_tdata, 8'h00);

    // Basic frame: 8-byte payload, grant after 3 cycles, no stalls.
    send_frame("basic", 16'd8, 8'h11, 32'hC0A8_0002, 48'h0011_2233_4455, 8, 3, 0, -1);
    if (got_q.size() >= 34) begin
      chk("basic_total_len", {got_q[16], got_q[17]}, 16'h001C);
      chk("basic_id", {got_q[18], got_q[19]}, 16'h0000);
    end

    // Same request with random stalls on both header and payload.
    send_frame("stall", 16'd8, 8'h11, 32'hC0A8_0002, 48'h0011_2233_4455, 8, 2, 1, -1);
    send_frame("stall_long", 16'd40, 8'h06, 32'h0A00_0005, 48'hA1B2_C3D4_E5F6, 40, 1, 1, -1);

    // Oversize request, then a valid one proceeds.
    send_frame("oversize", 16'd1481, 8'h11, 32'hC0A8_0003, 48'h0011_2233_4455, 0, 0, 0, -1);
    send_frame("after_err", 16'd5, 8'h11, 32'hC0A8_0003, 48'h0011_2233_4456, 5, 0, 0, -1);

    // Reset while header byte 20 is on the bus.
    send_frame("abort", 16'd16, 8'h11, 32'hC0A8_0004, 48'h0011_2233_4457, 16, 1, 0, 20);

    // Back-to-back after reset: identifications 0 then 1.
    send_frame("b2b_a", 16'd3, 8'h11, 32'hC0A8_0005, 48'h0203_0405_0607, 3, 0, 0, -1);
    if (got_q.size() >= 34) chk("b2b_a_id", {got_q[18], got_q[19]}, 16'h0000);
    send_frame("b2b_b", 16'd4, 8'h01, 32'hC0A8_0006, 48'h0203_0405_0608, 4, 0, 0, -1);
    if (got_q.size() >= 34) chk("b2b_b_id", {got_q[18], got_q[19]}, 16'h0001);

    // Header-only frame: tlast on byte 33.
    send_frame("len0", 16'd0, 8'h11, 32'hC0A8_0007, 48'h0011_2233_4458, 0, 2, 0, -1);

    // Largest legal payload.
    send_frame("maxlen", 16'd1480, 8'h11, 32'hFFFF_FFFF, 48'hFFFF_FFFF_FFFF, 1480, 0, 0, -1);

    // Declared 8, delivered 6.
    send_frame("short", 16'd8, 8'h11, 32'hC0A8_0008, 48'h0011_2233_4459, 6, 1, 0, -1);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ipv4_tx_framer.md
# ipv4_tx_framer

Transmit-side IPv4 framing stage that sits directly downstream of the UDP transmit block. It accepts a packet request plus byte stream on the `ip_tx` interface and arbitrates for the MAC transmit path. It then emits a 14-byte Ethernet header, a 20-byte IPv4 header with computed header checksum, and the upstream payload on a byte-wide AXI-style stream toward the MAC. Next-hop MAC resolution is external; this block takes the resolved destination MAC as an input.

## Interface
- `OUR_IP`, 32'hC0A8_0001, source IPv4 address.
- `OUR_MAC`, 48'h0023_2045_0001, source MAC address.
- `TTL`, 8'd128, IPv4 time-to-live.
- `MAX_DATA_LEN`, 16'd1480, largest accepted IP payload in bytes.

One clock; reset is synchronous and active-high.

- `clk` in 1 system clock.
- `reset` in 1 synchronous, active-high reset.
- `ip_tx_start` in 1 packet request, sampled in IDLE.
- `ip_tx` in `ipv4_tx_type` struct with these fields:
  - hdr: `protocol[7:0]`, `data_length[15:0]`, `dst_ip_addr[31:0]`.
  - data: `data_out[7:0]`, `data_out_valid`, `data_out_last`.
- `ip_tx_result` out 2 result code:
  - IPTX_NORMAL=2'b00
  - IPTX_SENDING=2'b01
  - IPTX_ERR=2'b10
- `ip_tx_data_out_ready` out 1 payload backpressure to upstream.
- `dst_mac` in 48 resolved next-hop MAC; stable while `ip_tx_start` is high.
- `mac_tx_req` out 1 request MAC transmit path.
- `mac_tx_granted` in 1 MAC arbiter grant.
- `mac_tx_tready` in 1 MAC accepts byte.
- `mac_tx_tvalid` out 1 byte valid.
- `mac_tx_tlast` out 1 last byte of frame.
- `mac_tx_tdata` out 8 frame byte.

## Operation
- FSM states:
  - IDLE: if `ip_tx_start` and `data_length` ≤ MAX_DATA_LEN:
    - latch hdr fields and `dst_mac`;
    - set result to SENDING;
    - go to WAIT_GRANT.
  - IDLE, oversize request: if `data_length` > MAX_DATA_LEN, set result to ERR and stay in IDLE. No request is made.
  - WAIT_GRANT: `mac_tx_req`=1; on `mac_tx_granted`=1 go to SEND_HDR.
  - SEND_HDR: 6-bit byte counter 0..33; the counter advances only on `tvalid & tready`. Byte order:
    - bytes 0–5: dst_mac, MSB first.
    - bytes 6–11: OUR_MAC.
    - bytes 12–13: 0x0800.
    - bytes 14–15: 0x45, 0x00.
    - bytes 16–17: total length = data_length + 20.
    - bytes 18–19: identification.
    - bytes 20–21: 0x40, 0x00 (DF set).
    - byte 22: TTL.
    - byte 23: protocol.
    - bytes 24–25: checksum.
    - bytes 26–29: OUR_IP.
    - bytes 30–33: dst_ip_addr.
    - After byte 33 is accepted, go to SEND_DATA.
  - SEND_DATA: combinational pass-through:
    - `mac_tx_tdata` = `data_out`;
    - `mac_tx_tvalid` = `data_out_valid`;
    - `mac_tx_tlast` = `data_out_last`;
    - `ip_tx_data_out_ready` = `mac_tx_tready`.
    - On an accepted last byte: `mac_tx_req` drops, result returns to NORMAL, identification increments, go to IDLE.
- Identification: 16-bit counter, reset 0; wraps 0xFFFF→0x0000.
- Checksum:
  - one's-complement sum of the ten header words, with the checksum word taken as 0;
  - accumulate in 20 bits, fold twice, then invert;
  - registered in the cycle after start acceptance.
- A new start is ignored outside IDLE.
- `ip_tx_data_out_ready` is 0 outside SEND_DATA.
- `data_length` = 0 is legal: the frame is header only, and `mac_tx_tlast` is asserted on byte 33.
- ERR result persists until the next accepted start.
- Reset mid-frame: FSM returns to IDLE next edge, all outputs drop, identification clears, the partial frame is abandoned.

## Timing
- Reset values:
  - `ip_tx_result`=NORMAL
  - `ip_tx_data_out_ready`=0
  - `mac_tx_req`=0
  - `mac_tx_tvalid`=0
  - `mac_tx_tlast`=0
  - `mac_tx_tdata`=0
- Start sampled at edge T: `mac_tx_req` and result=SENDING are visible after T.
- Grant sampled at edge G: first header byte is valid after G.
- With `tready` held high:
  - the header takes 34 cycles;
  - payload byte k appears in the same cycle as upstream `data_out` k (zero latency);
  - `mac_tx_req` is low the cycle after the last accepted byte.
- `mac_tx_tvalid`, `tdata` and `tlast` hold stable while `tready`=0.

## Configuration
- `IPV4_TX_LEN_CHECK_EN` defined:
  - a 16-bit payload counter compares the accepted byte count at `data_out_last` with `data_length`;
  - on mismatch, the result goes to ERR instead of NORMAL at frame end;
  - the frame still ends on upstream last.
- `IPV4_TX_LEN_CHECK_EN` undefined: no counter; frame end always yields NORMAL.

## Structure
- `global_typs_pkg`:
  - `ipv4_tx_type`, with hdr and data sub-structs;
  - IPTX_* result constants;
  - ETHERTYPE_IPV4=16'h0800;
  - IPV4_HDR_LEN=20;
  - ETH_HDR_LEN=14.
- Sub-module `ipv4_hdr_checksum`: combinational sum and fold over the header fields, registered by the parent.

## Test plan
- Send a request: length=8, protocol=0x11, dst=0xC0A80002, dst_mac=0x001122334455; grant after 3 cycles; `tready`=1.
  - Frame is 42 bytes.
  - Bytes 16–17 = 0x001C.
  - Bytes 24–25 equal the reference-model checksum.
  - `tlast` on byte 41.
  - Result sequence is SENDING then NORMAL.
- Send two back-to-back packets: identification bytes are 0x0000 then 0x0001; `mac_tx_req` drops between the frames.
- Drive random `tready` stalls through header and payload: the byte sequence is identical to the no-stall run, with no duplicated or dropped bytes.
- Request with length=1481: result=ERR, `mac_tx_req` never asserts, the next valid start proceeds normally.
- Assert reset at header byte 20: all outputs are 0 the next cycle, and a fresh packet afterwards uses identification 0x0000.
- With `IPV4_TX_LEN_CHECK_EN` defined, declare length=8 and deliver 6 bytes: result=ERR after `tlast`.
- With `IPV4_TX_LEN_CHECK_EN` undefined, repeat the same stimulus: result=NORMAL.
